// File: rtl/lsu_pkg.sv
// Shared types and helpers for the read-modify-write load/store unit.
package lsu_pkg;

   localparam int LSU_WIDTH = 32;
   localparam int BYTES     = LSU_WIDTH / 8;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Natural-alignment test only; the illegal size is screened separately.
   function automatic logic misaligned(input size_e size, input logic [1:0] offset);
      case (size)
         SZ_HALF: return offset[0];
         SZ_WORD: return (offset != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: load extraction/extension and sub-word store merge (combinational).
module lsu_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]         i_word,
   input  logic [$clog2(BYTES)-1:0] i_offset,
   input  size_e                    i_size,
   input  logic                     i_signed,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_load,
   output logic [WIDTH-1:0]         o_merged
);

   logic [$clog2(BYTES)+2:0] w_shamt;
   logic [WIDTH-1:0]         w_lane;
   logic [WIDTH-1:0]         w_mask;
   logic [WIDTH-1:0]         w_ins;

   assign w_shamt = {i_offset, 3'b000};
   assign w_lane  = i_word >> w_shamt;
   assign w_ins   = i_wdata << w_shamt;

   always_comb begin
      o_load = i_word;
      w_mask = '1;
      case (i_size)
         SZ_BYTE: begin
            o_load = {{(WIDTH-8){i_signed & w_lane[7]}}, w_lane[7:0]};
            w_mask = WIDTH'(8'hFF) << w_shamt;
         end
         SZ_HALF: begin
            o_load = {{(WIDTH-16){i_signed & w_lane[15]}}, w_lane[15:0]};
            w_mask = WIDTH'(16'hFFFF) << w_shamt;
         end
         default: ;
      endcase
      o_merged = (i_word & ~w_mask) | (w_ins & w_mask);
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only memory; sub-word stores run as read-modify-write.
// Optional LSU_PERF_CNT_EN adds saturating load/store/error response counters.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WIDTH-1:0]  resp_rdata,
   output logic              resp_err,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wd,
   input  logic [WIDTH-1:0]  mem_rd
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [15:0]       cnt_load,
   output logic [15:0]       cnt_store,
   output logic [15:0]       cnt_err
`endif
);

   state_e            r_state;
   state_e            w_next;
   logic              w_accept;
   logic              w_req_err;
   logic              r_we;
   size_e             r_size;
   logic              r_signed;
   logic [ADDR_W+1:0] r_addr;
   logic [WIDTH-1:0]  r_wdata;
   logic [WIDTH-1:0]  r_merged;
   logic [WIDTH-1:0]  r_rdata;
   logic              r_err;
   logic [WIDTH-1:0]  w_load;
   logic [WIDTH-1:0]  w_merged;

   assign w_req_err = misaligned(size_e'(req_size), req_addr[1:0]) || (size_e'(req_size) == SZ_ILL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Memory strobes come from the state register alone, so an async reset kills them at once.
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      req_ready = 1'b0;
      resp_valid = 1'b0;
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wd    = '0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept = 1'b1;
               if (w_req_err)                                    w_next = RESP;
               else if (req_we && size_e'(req_size) == SZ_WORD)  w_next = WRITE;
               else                                              w_next = READ;
            end
         end
         READ: begin
            mem_cs   = 1'b1;
            mem_addr = r_addr[ADDR_W+1:2];
            w_next   = r_we ? WRITE : RESP;
         end
         WRITE: begin
            mem_cs   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = r_addr[ADDR_W+1:2];
            mem_wd   = (r_size == SZ_WORD) ? r_wdata : r_merged;
            w_next   = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .i_word   (mem_rd),
      .i_offset (r_addr[1:0]),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_wdata  (r_wdata),
      .o_load   (w_load),
      .o_merged (w_merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_size   <= SZ_BYTE;
         r_signed <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_merged <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_we     <= req_we;
         r_size   <= size_e'(req_size);
         r_signed <= req_signed;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
         r_rdata  <= '0;
         r_err    <= w_req_err;
      end else if (r_state == READ) begin
         if (r_we) r_merged <= w_merged;
         else      r_rdata  <= w_load;
      end
   end

`ifdef LSU_PERF_CNT_EN
   logic w_enter_resp;
   assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_load  <= '0;
         cnt_store <= '0;
         cnt_err   <= '0;
      end else if (w_enter_resp) begin
         if (r_state == IDLE) begin
            if (cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
         end else if (r_we) begin
            if (cnt_store != 16'hFFFF) cnt_store <= cnt_store + 16'd1;
         end else begin
            if (cnt_load != 16'hFFFF) cnt_load <= cnt_load + 16'd1;
         end
      end
   end
`endif

endmodule
